// File: rtl/fb_pixel_writer_if.sv
// Pixel-producer and SRAM write-port bundle for fb_pixel_writer.
// master: producer/arbiter side that drives the inputs; slave: the writer itself.
interface fb_pixel_writer_if;
    logic        iPix_Valid;
    logic        oPix_Ready;
    logic [9:0]  iPix_X;
    logic [9:0]  iPix_Y;
    logic [3:0]  iPix_Red;
    logic [3:0]  iPix_Green;
    logic [3:0]  iPix_Blue;
    logic        iWr_Grant;
    logic [17:0] oSRAM_Addr;
    logic [15:0] oSRAM_Data;
    logic        oSRAM_WE_N;
    logic [2:0]  oFifo_Level;
    logic [15:0] oDrop_Count;
    logic        oBusy;

    modport master (
        output iPix_Valid, iPix_X, iPix_Y, iPix_Red, iPix_Green, iPix_Blue, iWr_Grant,
        input  oPix_Ready, oSRAM_Addr, oSRAM_Data, oSRAM_WE_N, oFifo_Level, oDrop_Count, oBusy
    );

    modport slave (
        input  iPix_Valid, iPix_X, iPix_Y, iPix_Red, iPix_Green, iPix_Blue, iWr_Grant,
        output oPix_Ready, oSRAM_Addr, oSRAM_Data, oSRAM_WE_N, oFifo_Level, oDrop_Count, oBusy
    );
endinterface

// File: rtl/fb_pixel_writer.sv
// Buffers RGB444 pixels in a small FIFO and writes them to a shared SRAM port in 4-cycle slots.
// Optional framebuffer clear engine is built when FB_CLEAR_EN is defined.
//
// state  | meaning
// IDLE   | waiting for FIFO data (or a pending clear) and iWr_Grant
// SETUP  | address/data driven, WE_N high
// STROBE | WE_N low for exactly one cycle
// HOLD   | address/data held, WE_N high, then back to IDLE
module fb_pixel_writer #(
    parameter int unsigned H_RES      = 640,
    parameter int unsigned V_RES      = 400,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic             iCLK,
    input  logic             iRST_N,
`ifdef FB_CLEAR_EN
    input  logic             iClear,
    input  logic [11:0]      iClear_Color,
    output logic             oClearing,
`endif
    fb_pixel_writer_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_STROBE = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
    localparam logic [2:0]  LVL_FULL = 3'(FIFO_DEPTH);

    state_t             r_state;
    state_t             w_state_nxt;

    logic [17:0]        r_fifo_addr [FIFO_DEPTH];
    logic [11:0]        r_fifo_rgb  [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [2:0]         r_count;
    logic [2:0]         w_count_nxt;

    logic               w_in_range;
    logic               w_accept;
    logic               w_push;
    logic               w_pop;
    logic               w_start;
    logic [17:0]        w_pix_addr;

    logic               w_clearing;
    logic               w_clearing_nxt;
    logic               w_clr_start;
    logic [17:0]        w_clr_addr;
    logic [11:0]        w_clr_rgb;

    logic [17:0]        r_addr;
    logic [15:0]        r_data;
    logic               r_we_n;
    logic               r_ready;
    logic               r_busy;
    logic [15:0]        r_drop;

    logic [17:0]        w_addr_nxt;
    logic [15:0]        w_data_nxt;
    logic               w_we_n_nxt;
    logic               w_ready_nxt;
    logic               w_busy_nxt;
    logic [15:0]        w_drop_nxt;

    // Input qualification and address generation; in-range results never exceed 18 bits
    assign w_in_range = (32'(bus.iPix_X) < H_RES) && (32'(bus.iPix_Y) < V_RES);
    assign w_accept   = bus.iPix_Valid && r_ready;
    assign w_push     = w_accept && w_in_range;
    assign w_pix_addr = 18'(bus.iPix_Y) * 18'(H_RES) + 18'(bus.iPix_X);

    // A pending clear owns the port ahead of any buffered pixels
    assign w_pop   = (r_state == S_IDLE) && bus.iWr_Grant && (r_count != 3'd0) && !w_clearing;
    assign w_start = w_pop || w_clr_start;

`ifdef FB_CLEAR_EN
    localparam logic [17:0] CLR_LAST = 18'(H_RES * V_RES - 1);

    logic        r_clearing;
    logic [17:0] r_clr_addr;
    logic        r_clr_last;
    logic        w_clr_done;

    assign w_clr_start    = r_clearing && (r_state == S_IDLE) && bus.iWr_Grant;
    assign w_clr_done     = r_clr_last && (r_state == S_HOLD);
    assign w_clearing     = r_clearing;
    assign w_clearing_nxt = r_clearing ? !w_clr_done : iClear;
    assign w_clr_addr     = r_clr_addr;
    assign w_clr_rgb      = iClear_Color;
    assign oClearing      = r_clearing;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_clearing <= 1'b0;
            r_clr_addr <= '0;
            r_clr_last <= 1'b0;
        end else begin
            r_clearing <= w_clearing_nxt;
            if (!r_clearing && iClear) begin
                r_clr_addr <= '0;
            end else if (w_clr_start) begin
                r_clr_addr <= r_clr_addr + 18'd1;
            end
            if (w_clr_start) begin
                r_clr_last <= (r_clr_addr == CLR_LAST);
            end else if (w_clr_done) begin
                r_clr_last <= 1'b0;
            end
        end
    end
`else
    assign w_clearing     = 1'b0;
    assign w_clearing_nxt = 1'b0;
    assign w_clr_start    = 1'b0;
    assign w_clr_addr     = '0;
    assign w_clr_rgb      = '0;
`endif

    // FIFO storage carries no reset; pointers and count define what is valid
    always_ff @(posedge iCLK) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= w_pix_addr;
            r_fifo_rgb[r_wr_ptr]  <= {bus.iPix_Red, bus.iPix_Green, bus.iPix_Blue};
        end
    end

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 3'd1;
            2'b01:   w_count_nxt = r_count - 3'd1;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= 3'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_nxt;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // iWr_Grant only matters in IDLE; once started, a write always runs to HOLD
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:   w_state_nxt = w_start ? S_SETUP : S_IDLE;
            S_SETUP:  w_state_nxt = S_STROBE;
            S_STROBE: w_state_nxt = S_HOLD;
            S_HOLD:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_addr_nxt = r_addr;
        w_data_nxt = r_data;
        if (w_clr_start) begin
            w_addr_nxt = w_clr_addr;
            w_data_nxt = {4'b0000, w_clr_rgb};
        end else if (w_pop) begin
            w_addr_nxt = r_fifo_addr[r_rd_ptr];
            w_data_nxt = {4'b0000, r_fifo_rgb[r_rd_ptr]};
        end
        w_we_n_nxt  = (w_state_nxt != S_STROBE);
        w_busy_nxt  = (w_state_nxt != S_IDLE) || (w_count_nxt != 3'd0);
        w_ready_nxt = (w_count_nxt != LVL_FULL) && !w_clearing_nxt;
        w_drop_nxt  = r_drop;
        if (w_accept && !w_in_range && (r_drop != 16'hFFFF)) begin
            w_drop_nxt = r_drop + 16'd1;
        end
    end

    // Ready resets high: an empty FIFO can take a pixel on the first edge after release
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_addr  <= '0;
            r_data  <= '0;
            r_we_n  <= 1'b1;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_drop  <= '0;
        end else begin
            r_addr  <= w_addr_nxt;
            r_data  <= w_data_nxt;
            r_we_n  <= w_we_n_nxt;
            r_ready <= w_ready_nxt;
            r_busy  <= w_busy_nxt;
            r_drop  <= w_drop_nxt;
        end
    end

    assign bus.oPix_Ready  = r_ready;
    assign bus.oSRAM_Addr  = r_addr;
    assign bus.oSRAM_Data  = r_data;
    assign bus.oSRAM_WE_N  = r_we_n;
    assign bus.oFifo_Level = r_count;
    assign bus.oDrop_Count = r_drop;
    assign bus.oBusy       = r_busy;

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Self-checking bench for fb_pixel_writer (default build): directed scenarios plus a
// randomized stream compared against a queue-based model of accepted pixels.
module tb_fb_pixel_writer;
    localparam int H = 640;
    localparam int V = 400;

    typedef struct {
        logic [17:0] a;
        logic [15:0] d;
        int          c;
    } wr_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    int          cyc   = 0;
    int          n_vec = 0;
    int          n_err = 0;
    bit          rand_grant = 1'b0;
    logic [15:0] exp_drop = 16'd0;
    wr_t         obs_q[$];
    wr_t         exp_q[$];

`ifdef FB_CLEAR_EN
    logic        clr_req = 1'b0;
    logic [11:0] clr_col = 12'h000;
    logic        clearing;
`endif

    fb_pixel_writer_if bus();

    fb_pixel_writer #(.H_RES(H), .V_RES(V), .FIFO_DEPTH(4)) dut (
        .iCLK         (clk),
        .iRST_N       (rst_n),
`ifdef FB_CLEAR_EN
        .iClear       (clr_req),
        .iClear_Color (clr_col),
        .oClearing    (clearing),
`endif
        .bus          (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Every cycle with WE_N low is one SRAM write; record it with its cycle index
    always @(negedge clk) begin
        if (rst_n && bus.oSRAM_WE_N === 1'b0) begin
            obs_q.push_back('{a: bus.oSRAM_Addr, d: bus.oSRAM_Data, c: cyc});
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
        #1;
        if (rand_grant) bus.iWr_Grant = ($urandom_range(0, 3) != 0);
    endtask

    // Reference model: out-of-range pixels only bump a saturating counter,
    // in-range pixels become (row-major address, zero-extended colour) writes in order.
    function automatic void model_accept(input int x, input int y, input logic [11:0] rgb);
        wr_t w;
        if (x >= H || y >= V) begin
            if (exp_drop != 16'hFFFF) exp_drop = exp_drop + 16'd1;
        end else begin
            w.a = 18'(y * H + x);
            w.d = {4'h0, rgb};
            w.c = 0;
            exp_q.push_back(w);
        end
    endfunction

    task automatic send_pix(input int x, input int y, input logic [11:0] rgb);
        bit ok;
        ok = 1'b0;
        bus.iPix_Valid = 1'b1;
        bus.iPix_X     = 10'(x);
        bus.iPix_Y     = 10'(y);
        bus.iPix_Red   = rgb[11:8];
        bus.iPix_Green = rgb[7:4];
        bus.iPix_Blue  = rgb[3:0];
        for (int n = 0; n < 64; n++) begin
            if (bus.oPix_Ready === 1'b1) begin
                model_accept(x, y, rgb);
                ok = 1'b1;
                tick();
                break;
            end
            tick();
        end
        bus.iPix_Valid = 1'b0;
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: pixel (%0d,%0d) not accepted within 64 cycles", x, y);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        n_vec++; if (bus.oSRAM_WE_N !== 1'b1) begin n_err++; $display("FAIL rst_we_n: got %b exp 1", bus.oSRAM_WE_N); end
        n_vec++; if (bus.oFifo_Level !== 3'd0) begin n_err++; $display("FAIL rst_level: got %0d exp 0", bus.oFifo_Level); end
        n_vec++; if (bus.oDrop_Count !== 16'd0) begin n_err++; $display("FAIL rst_drop: got %0d exp 0", bus.oDrop_Count); end
        n_vec++; if (bus.oSRAM_Addr !== 18'd0) begin n_err++; $display("FAIL rst_addr: got %0d exp 0", bus.oSRAM_Addr); end
        n_vec++; if (bus.oSRAM_Data !== 16'd0) begin n_err++; $display("FAIL rst_data: got %h exp 0000", bus.oSRAM_Data); end
        n_vec++; if (bus.oBusy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b exp 0", bus.oBusy); end
        rst_n = 1'b1;
        tick();
        n_vec++; if (bus.oPix_Ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b exp 1", bus.oPix_Ready); end
    endtask

    task automatic test_single_write();
        int k;
        wr_t o, e;
        bus.iWr_Grant = 1'b1;
        send_pix(5, 2, 12'hABC);
        k = cyc;
        tick();
        n_vec++; if (bus.oSRAM_Addr !== 18'd1285 || bus.oSRAM_WE_N !== 1'b1 || bus.oBusy !== 1'b1) begin
            n_err++; $display("FAIL single_setup: got addr=%0d we_n=%b busy=%b exp 1285/1/1", bus.oSRAM_Addr, bus.oSRAM_WE_N, bus.oBusy);
        end
        tick();
        n_vec++; if (bus.oSRAM_WE_N !== 1'b0 || bus.oSRAM_Addr !== 18'd1285 || bus.oSRAM_Data !== 16'h0ABC) begin
            n_err++; $display("FAIL single_strobe: got we_n=%b addr=%0d data=%h exp 0/1285/0abc", bus.oSRAM_WE_N, bus.oSRAM_Addr, bus.oSRAM_Data);
        end
        tick();
        n_vec++; if (bus.oSRAM_WE_N !== 1'b1 || bus.oSRAM_Addr !== 18'd1285 || bus.oSRAM_Data !== 16'h0ABC) begin
            n_err++; $display("FAIL single_hold: got we_n=%b addr=%0d data=%h exp 1/1285/0abc", bus.oSRAM_WE_N, bus.oSRAM_Addr, bus.oSRAM_Data);
        end
        tick();
        n_vec++; if (bus.oBusy !== 1'b0) begin n_err++; $display("FAIL single_idle: got busy=%b exp 0", bus.oBusy); end
        n_vec++; if (obs_q.size() != 1 || exp_q.size() != 1) begin
            n_err++; $display("FAIL single_count: got %0d writes exp 1", obs_q.size());
        end else begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_vec++; if (o.a !== e.a || o.d !== e.d || o.c != k + 2) begin
                n_err++; $display("FAIL single_write: got %0d/%h@%0d exp %0d/%h@%0d", o.a, o.d, o.c, e.a, e.d, k + 2);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_fill_drain();
        int t0;
        wr_t o, e;
        bus.iWr_Grant = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send_pix($urandom_range(0, H - 1), $urandom_range(0, V - 1), 12'($urandom));
        end
        bus.iPix_Valid = 1'b1;
        bus.iPix_X = 10'd7;
        bus.iPix_Y = 10'd7;
        tick();
        n_vec++; if (bus.oPix_Ready !== 1'b0) begin n_err++; $display("FAIL fill_ready: got %b exp 0", bus.oPix_Ready); end
        n_vec++; if (bus.oFifo_Level !== 3'd4) begin n_err++; $display("FAIL fill_level: got %0d exp 4", bus.oFifo_Level); end
        bus.iPix_Valid = 1'b0;
        bus.iWr_Grant = 1'b1;
        t0 = cyc;
        repeat (15) tick();
        n_vec++; if (bus.oBusy !== 1'b1) begin n_err++; $display("FAIL fill_busy15: got %b exp 1", bus.oBusy); end
        tick();
        n_vec++; if (bus.oBusy !== 1'b0 || bus.oFifo_Level !== 3'd0) begin
            n_err++; $display("FAIL fill_done16: got busy=%b level=%0d exp 0/0", bus.oBusy, bus.oFifo_Level);
        end
        n_vec++; if (obs_q.size() != exp_q.size()) begin
            n_err++; $display("FAIL fill_count: got %0d writes exp %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; obs_q.size() > 0 && exp_q.size() > 0; i++) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_vec++; if (o.a !== e.a || o.d !== e.d || o.c != t0 + 2 + 4 * i) begin
                n_err++; $display("FAIL fill_write: got %0d/%h@%0d exp %0d/%h@%0d", o.a, o.d, o.c, e.a, e.d, t0 + 2 + 4 * i);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_drop();
        wr_t o, e;
        bus.iWr_Grant = 1'b1;
        send_pix(H, 0, 12'h111);
        n_vec++; if (bus.oPix_Ready !== 1'b1) begin n_err++; $display("FAIL drop_ready_x: got %b exp 1", bus.oPix_Ready); end
        send_pix(0, V, 12'h222);
        n_vec++; if (bus.oPix_Ready !== 1'b1) begin n_err++; $display("FAIL drop_ready_y: got %b exp 1", bus.oPix_Ready); end
        repeat (6) tick();
        n_vec++; if (obs_q.size() != 0) begin n_err++; $display("FAIL drop_nowrite: got %0d writes exp 0", obs_q.size()); end
        n_vec++; if (bus.oDrop_Count !== exp_drop || bus.oDrop_Count !== 16'd2) begin
            n_err++; $display("FAIL drop_count: got %0d exp %0d", bus.oDrop_Count, exp_drop);
        end
        send_pix(H - 1, V - 1, 12'($urandom));
        repeat (6) tick();
        n_vec++; if (obs_q.size() != 1 || exp_q.size() != 1) begin
            n_err++; $display("FAIL corner_count: got %0d writes exp 1", obs_q.size());
        end else begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_vec++; if (o.a !== e.a || o.d !== e.d || o.a !== 18'd255999) begin
                n_err++; $display("FAIL corner_write: got %0d/%h exp %0d/%h", o.a, o.d, e.a, e.d);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_grant_drop();
        bit seen;
        wr_t o, e;
        bus.iWr_Grant = 1'b1;
        send_pix($urandom_range(0, H - 1), $urandom_range(0, V - 1), 12'($urandom));
        send_pix($urandom_range(0, H - 1), $urandom_range(0, V - 1), 12'($urandom));
        seen = 1'b0;
        for (int n = 0; n < 12 && !seen; n++) begin
            if (bus.oSRAM_WE_N === 1'b0) seen = 1'b1;
            else tick();
        end
        n_vec++; if (!seen) begin n_err++; $display("FAIL grant_strobe: got no strobe within 12 cycles exp one"); end
        bus.iWr_Grant = 1'b0;
        repeat (10) tick();
        n_vec++; if (obs_q.size() != 1) begin n_err++; $display("FAIL grant_first: got %0d writes exp 1", obs_q.size()); end
        n_vec++; if (bus.oFifo_Level !== 3'd1 || bus.oBusy !== 1'b1 || bus.oSRAM_WE_N !== 1'b1) begin
            n_err++; $display("FAIL grant_wait: got level=%0d busy=%b we_n=%b exp 1/1/1", bus.oFifo_Level, bus.oBusy, bus.oSRAM_WE_N);
        end
        bus.iWr_Grant = 1'b1;
        repeat (6) tick();
        n_vec++; if (obs_q.size() != exp_q.size()) begin
            n_err++; $display("FAIL grant_count: got %0d writes exp %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_vec++; if (o.a !== e.a || o.d !== e.d) begin
                n_err++; $display("FAIL grant_write: got %0d/%h exp %0d/%h", o.a, o.d, e.a, e.d);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_random();
        int  prev_c;
        bit  have_prev;
        wr_t o, e;
        rand_grant = 1'b1;
        for (int i = 0; i < 150; i++) begin
            send_pix($urandom_range(0, 700), $urandom_range(0, 450), 12'($urandom));
            repeat ($urandom_range(0, 2)) tick();
        end
        rand_grant = 1'b0;
        bus.iWr_Grant = 1'b1;
        for (int n = 0; n < 40 && bus.oBusy === 1'b1; n++) tick();
        n_vec++; if (bus.oBusy !== 1'b0 || bus.oFifo_Level !== 3'd0) begin
            n_err++; $display("FAIL rand_drain: got busy=%b level=%0d exp 0/0", bus.oBusy, bus.oFifo_Level);
        end
        n_vec++; if (bus.oDrop_Count !== exp_drop) begin
            n_err++; $display("FAIL rand_drop: got %0d exp %0d", bus.oDrop_Count, exp_drop);
        end
        n_vec++; if (obs_q.size() != exp_q.size()) begin
            n_err++; $display("FAIL rand_count: got %0d writes exp %0d", obs_q.size(), exp_q.size());
        end
        have_prev = 1'b0;
        prev_c = 0;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_vec++; if (o.a !== e.a || o.d !== e.d) begin
                n_err++; $display("FAIL rand_write: got %0d/%h exp %0d/%h", o.a, o.d, e.a, e.d);
            end
            if (have_prev) begin
                n_vec++; if (o.c - prev_c < 4) begin
                    n_err++; $display("FAIL rand_spacing: got %0d cycles between strobes exp >= 4", o.c - prev_c);
                end
            end
            prev_c = o.c;
            have_prev = 1'b1;
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_mid_write();
        bit seen;
        bus.iWr_Grant = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send_pix($urandom_range(0, H - 1), $urandom_range(0, V - 1), 12'($urandom));
        end
        seen = 1'b0;
        for (int n = 0; n < 12 && !seen; n++) begin
            if (bus.oSRAM_WE_N === 1'b0) seen = 1'b1;
            else tick();
        end
        n_vec++; if (!seen) begin n_err++; $display("FAIL rstw_strobe: got no strobe within 12 cycles exp one"); end
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (bus.oSRAM_WE_N !== 1'b1) begin n_err++; $display("FAIL rstw_async: got we_n=%b exp 1", bus.oSRAM_WE_N); end
        n_vec++; if (bus.oFifo_Level !== 3'd0 || bus.oBusy !== 1'b0) begin
            n_err++; $display("FAIL rstw_flush: got level=%0d busy=%b exp 0/0", bus.oFifo_Level, bus.oBusy);
        end
        obs_q.delete(); exp_q.delete();
        exp_drop = 16'd0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (12) tick();
        n_vec++; if (obs_q.size() != 0) begin n_err++; $display("FAIL rstw_nowrite: got %0d writes exp 0", obs_q.size()); end
        n_vec++; if (bus.oFifo_Level !== 3'd0 || bus.oDrop_Count !== exp_drop) begin
            n_err++; $display("FAIL rstw_state: got level=%0d drop=%0d exp 0/%0d", bus.oFifo_Level, bus.oDrop_Count, exp_drop);
        end
    endtask

    initial begin
        bus.iPix_Valid = 1'b0;
        bus.iPix_X     = 10'd0;
        bus.iPix_Y     = 10'd0;
        bus.iPix_Red   = 4'd0;
        bus.iPix_Green = 4'd0;
        bus.iPix_Blue  = 4'd0;
        bus.iWr_Grant  = 1'b0;
        test_reset();
        test_single_write();
        test_fill_drain();
        test_drop();
        test_grant_drop();
        test_random();
        test_reset_mid_write();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/fb_pixel_writer.md
FB_PIXEL_WRITER -- requirements
Module: fb_pixel_writer

Interface
REQ-001 SHALL have parameter H_RES, default 640, pixels per framebuffer line.
REQ-002 SHALL have parameter V_RES, default 400, framebuffer lines (address space 0..255999).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, pixel FIFO entries (power of two).
REQ-004 iCLK  in  1  clock; reset iRST_N, asynchronous, active-low; clock iCLK.
REQ-005 iRST_N  in  1  asynchronous active-low reset.
REQ-006 iPix_Valid  in  1  producer offers a pixel.
REQ-007 oPix_Ready  out  1  pixel accepted on a cycle where iPix_Valid and oPix_Ready are both 1.
REQ-008 iPix_X / iPix_Y  in  10 each  pixel coordinate in framebuffer space.
REQ-009 iPix_Red / iPix_Green / iPix_Blue  in  4 each  RGB444 colour.
REQ-010 iWr_Grant  in  1  SRAM port free for a write starting this cycle (display reader not using it).
REQ-011 oSRAM_Addr  out  18  write address; oSRAM_Data out 16 write data; oSRAM_WE_N out 1 active-low write strobe.
REQ-012 oFifo_Level  out  3  current FIFO occupancy; oDrop_Count out 16 discarded-pixel count; oBusy out 1 FSM not IDLE or FIFO non-empty.

Function
REQ-013 oPix_Ready SHALL equal (FIFO not full) and not clearing, independent of iPix_Valid.
REQ-014 Accepted pixel with X >= H_RES or Y >= V_RES SHALL be discarded (not pushed) and oDrop_Count incremented, saturating at 0xFFFF.
REQ-015 In-range accepted pixel SHALL be pushed as address Y*H_RES+X (18-bit, no truncation) and data {4'b0000, R, G, B}.
REQ-016 FSM states: IDLE, SETUP, STROBE, HOLD; IDLE->SETUP when FIFO non-empty and iWr_Grant=1, popping the head into the address/data registers on that edge.
REQ-017 SETUP->STROBE->HOLD->IDLE unconditionally, one cycle each; oSRAM_WE_N=0 only in STROBE; oSRAM_Addr/oSRAM_Data stable from SETUP through HOLD.
REQ-018 iWr_Grant SHALL be sampled only in IDLE; deassertion during SETUP/STROBE/HOLD SHALL NOT abort the write.
REQ-019 Latency: pixel accepted at edge k into empty FIFO with grant held high -> SETUP after edge k+1, WE_N low after edge k+2, IDLE after edge k+4; sustained throughput one write per 4 cycles.
REQ-020 Simultaneous push and pop SHALL keep oFifo_Level unchanged; pixels SHALL be written in acceptance order.
REQ-021 All outputs SHALL be registered; oSRAM_WE_N SHALL be 1 whenever the FSM is not in STROBE.

Reset
REQ-022 On iRST_N=0: FSM IDLE, FIFO empty, oFifo_Level=0, oDrop_Count=0, oSRAM_Addr=0, oSRAM_Data=0, oSRAM_WE_N=1, oBusy=0, clear state idle.
REQ-023 Reset asserted mid-write SHALL force oSRAM_WE_N=1 immediately (asynchronously) and discard the in-flight pixel and FIFO contents.
REQ-024 oPix_Ready SHALL be 1 on the first edge after reset release.

Configuration
REQ-025 Macro FB_CLEAR_EN defined: adds ports iClear (in 1), iClear_Color (in 12), oClearing (out 1).
REQ-026 With FB_CLEAR_EN: iClear=1 latches a request; oClearing=1 from next edge; oPix_Ready=0 while clearing; when FSM reaches IDLE, clear writes addresses 0..H_RES*V_RES-1 with {4'b0000, iClear_Color} using the same IDLE/SETUP/STROBE/HOLD cycle and grant rule, ahead of FIFO entries.
REQ-027 With FB_CLEAR_EN: iClear during clearing SHALL be ignored; oClearing falls after HOLD of address H_RES*V_RES-1; retained FIFO entries then drain normally.
REQ-028 Without FB_CLEAR_EN: ports absent, no clear counter logic, behaviour per REQ-013..021 only.

Verification
REQ-029 Push X=5,Y=2,RGB=A/B/C, grant=1 -> one STROBE with Addr=1285, Data=0x0ABC, WE_N low exactly 1 cycle at edge k+3.
REQ-030 Push 5 pixels back-to-back with grant=0 -> oPix_Ready drops after 4, oFifo_Level=4; raise grant -> 4 writes in order, 16 cycles.
REQ-031 Push X=640,Y=0 then X=0,Y=400 -> no SRAM writes, oDrop_Count=2, oPix_Ready stays 1.
REQ-032 Drop grant during STROBE -> write completes, next write waits in IDLE until grant=1.
REQ-033 Assert iRST_N=0 during STROBE -> WE_N=1 immediately, oFifo_Level=0 after reset, no further writes.
REQ-034 FB_CLEAR_EN, iClear with color 0x123, grant=1 -> 256000 writes Data=0x0123, last Addr=255999, oClearing low after 1024000 cycles.
